fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit
Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports imem_req  output  1  and imem_addr  output  32, the instruction-memory request and word address.
REQ-005 SHALL have ports imem_ack  input  1  and imem_rdata  input  32, the memory acknowledge and returned instruction.
REQ-006 SHALL have ports instr_valid  output  1,  instr_ready  input  1, and instr  output  32, the handshake to decode; instr[31:26] drives control's opcode input.
REQ-007 SHALL have ports pc_out  output  32  and pc_plus4  output  32, the PC of the held instruction and that PC+4.
REQ-008 SHALL have inputs jump  1,  branch  1,  zero  1,  branch_offset  32 (sign-extended immediate),  jump_index  26.
REQ-009 SHALL have port trap  output  1, the misalignment trap flag, present only under MISALIGN_TRAP_EN.
Function
REQ-010 SHALL implement states FETCH (imem_req=1), VALID (instr_valid=1) and, under MISALIGN_TRAP_EN, TRAP.
REQ-011 SHALL, in FETCH, hold imem_req=1 and imem_addr=pc constant until the cycle imem_ack=1.
REQ-012 SHALL, on imem_ack in FETCH, register imem_rdata into instr and enter VALID next cycle.
REQ-013 SHALL ignore imem_ack in any state other than FETCH.
REQ-014 SHALL, in VALID, hold instr, pc_out and instr_valid stable until instr_valid && instr_ready.
REQ-015 SHALL sample jump, branch, zero, branch_offset and jump_index only in the handshake cycle.
REQ-016 SHALL, on handshake, load pc with next_pc and enter FETCH next cycle; minimum two cycles per instruction.
REQ-017 SHALL compute next_pc = {pc_plus4[31:28], jump_index, 2'b00} when jump=1.
REQ-018 SHALL compute next_pc = pc_plus4 + (branch_offset << 2), modulo 2^32, when jump=0, branch=1 and zero=1.
REQ-019 SHALL compute next_pc = pc_plus4 otherwise; jump has priority over branch when both are asserted.
REQ-020 SHALL wrap pc_plus4 from 32'hFFFF_FFFC to 32'h0000_0000 without flagging an error.
REQ-021 SHALL drive imem_req=0 and instr_valid=0 outside FETCH and VALID respectively.
Reset
REQ-022 SHALL, on a clock edge with rst_n=0, set pc=RESET_PC, state=FETCH, instr=0, trap=0.
REQ-023 SHALL drive imem_req=0 and instr_valid=0 while rst_n=0.
REQ-024 SHALL discard any imem_ack or handshake occurring in a cycle with rst_n=0, including mid-fetch.
REQ-025 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst_n returns to 1.
Configuration
REQ-026 SHALL compile the misalignment trap in only when macro MISALIGN_TRAP_EN is defined.
REQ-027 SHALL, with MISALIGN_TRAP_EN, enter TRAP instead of FETCH when next_pc[1:0] != 0, assert trap, and keep imem_req=0 and instr_valid=0 until reset.
REQ-028 SHALL, without MISALIGN_TRAP_EN, omit the trap port and force imem_addr[1:0]=2'b00.
Structure
REQ-029 SHALL take the state encoding, RESET_PC default and opcode width constants from the shared cpu package, alongside the control opcode constants.
REQ-030 SHALL isolate the next-PC computation in sub-module next_pc_calc, combinational, with inputs pc_plus4 and the redirect signals.
Verification
REQ-031 SHALL check reset release: imem_req=1 and imem_addr=0 in cycle 1; ack with rdata=32'h8C01_0004 gives instr_valid=1 and instr=32'h8C01_0004 in cycle 2.
REQ-032 SHALL check stall: instr_ready=0 for 5 cycles holds instr and pc_out constant; ready=1 gives imem_addr=4 the next cycle.
REQ-033 SHALL check branch: pc=0x10, branch=1, zero=1, branch_offset=-2 gives next imem_addr=0x0C; the same with zero=0 gives 0x14.
REQ-034 SHALL check jump priority: pc=0x1000_0000, jump=1, branch=1, zero=1, jump_index=0x40 gives imem_addr=0x1000_0100.
REQ-035 SHALL check reset mid-fetch: rst_n=0 during the ack cycle gives no instr_valid, then a refetch from RESET_PC.
REQ-036 SHALL check, with MISALIGN_TRAP_EN, that a jump target with next_pc[1:0]=2'b10 forced through a testbench hook asserts trap and keeps imem_req=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants: fetch FSM encoding, reset PC default, opcode width and control opcodes.
package fetch_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned JIDX_W   = 26;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Control opcodes decoded from instr[31:26]
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_TRAP  = 2'd2
    } fetch_state_e;

    // Redirect request from execute, sampled in the decode handshake cycle
    typedef struct packed {
        logic              jump;
        logic              branch;
        logic              zero;
        logic [XLEN-1:0]   branch_offset;
        logic [JIDX_W-1:0] jump_index;
    } redirect_t;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory request, decode handshake and redirect inputs.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_ack;
    logic [XLEN-1:0]   imem_rdata;

    logic              instr_valid;
    logic              instr_ready;
    logic [XLEN-1:0]   instr;
    logic [XLEN-1:0]   pc_out;
    logic [XLEN-1:0]   pc_plus4;

    logic              jump;
    logic              branch;
    logic              zero;
    logic [XLEN-1:0]   branch_offset;
    logic [JIDX_W-1:0] jump_index;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc_out, pc_plus4,
        input  imem_ack, imem_rdata, instr_ready,
        input  jump, branch, zero, branch_offset, jump_index
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc_out, pc_plus4,
        output imem_ack, imem_rdata, instr_ready,
        output jump, branch, zero, branch_offset, jump_index
    );

endinterface

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump beats taken branch beats sequential.
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc_plus4,
    input  redirect_t       redirect,
    output logic [XLEN-1:0] next_pc_c
);

    // Priority select of the redirect target
    always_comb begin
        next_pc_c = pc_plus4;
        if (redirect.jump) begin
            next_pc_c = {pc_plus4[31:28], redirect.jump_index, 2'b00};
        end else if (redirect.branch && redirect.zero) begin
            next_pc_c = pc_plus4 + (redirect.branch_offset << 2);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH -> VALID loop with PC redirect on decode handshake.
// Optional misalignment trap compiled in with macro MISALIGN_TRAP_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
`ifdef MISALIGN_TRAP_EN
    output logic trap,
`endif
    fetch_unit_if.master bus
);

    fetch_state_e    state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_plus4_c;
    logic [XLEN-1:0] next_pc_c;
    redirect_t       redirect;

`ifdef MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    assign trap = trap_q;
`endif

    assign pc_plus4_c = pc + 32'd4;

    // Pack redirect inputs for the next-PC calculator
    always_comb begin
        redirect.jump          = bus.jump;
        redirect.branch        = bus.branch;
        redirect.zero          = bus.zero;
        redirect.branch_offset = bus.branch_offset;
        redirect.jump_index    = bus.jump_index;
    end

    next_pc_calc u_next_pc (
        .pc_plus4  (pc_plus4_c),
        .redirect  (redirect),
        .next_pc_c (next_pc_c)
    );

    // State, PC and instruction registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            instr_q <= '0;
`ifdef MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            instr_q <= instr_d;
`ifdef MISALIGN_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    // Next-state logic; imem_ack only matters in FETCH, redirects only on handshake
    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = instr_q;
`ifdef MISALIGN_TRAP_EN
        trap_d  = trap_q;
`endif
        case (state)
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (bus.instr_ready) begin
                    pc_d    = next_pc_c;
                    state_d = ST_FETCH;
`ifdef MISALIGN_TRAP_EN
                    if (!is_aligned(next_pc_c[1:0])) begin
                        state_d = ST_TRAP;
                        trap_d  = 1'b1;
                    end
`endif
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Handshake strobes decode the state register and are held low during reset
    assign bus.imem_req    = rst_n && (state == ST_FETCH);
    assign bus.instr_valid = rst_n && (state == ST_VALID);
    assign bus.instr       = instr_q;
    assign bus.pc_out      = pc;
    assign bus.pc_plus4    = pc_plus4_c;

`ifdef MISALIGN_TRAP_EN
    assign bus.imem_addr   = pc;
`else
    assign bus.imem_addr   = {pc[31:2], 2'b00};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, redirect vector table,
// randomized instruction stream against a transaction-level PC model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if bus();

`ifdef MISALIGN_TRAP_EN
    logic trap;
    logic trap2;
    fetch_unit_if bus2();
    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .trap(trap), .bus(bus));
    fetch_unit #(.RESET_PC(32'h0000_0002)) dut2 (.clk(clk), .rst_n(rst_n), .trap(trap2), .bus(bus2));
`else
    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] mpc;
    logic [31:0] minstr;

    typedef struct {
        string       name;
        logic [31:0] start_pc;
        logic        j;
        logic        b;
        logic        z;
        logic [31:0] off;
        logic [25:0] idx;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural next-PC rule, in plain arithmetic
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic j, input logic b,
                                             input logic z, input logic [31:0] off, input logic [25:0] idx);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | (32'(idx) * 32'd4);
        if (b && z) return seq + off * 32'd4;
        return seq;
    endfunction

    // Serve one fetch after 'delay' wait cycles; starts and ends at a negedge
    task automatic fetch_one(input logic [31:0] data, input int delay);
        for (int i = 0; i < delay; i++) begin
            check1("req_wait", bus.imem_req, 1'b1);
            check32("addr_wait", bus.imem_addr, mpc);
            check1("valid_wait", bus.instr_valid, 1'b0);
            @(negedge clk);
        end
        check1("req", bus.imem_req, 1'b1);
        check32("addr", bus.imem_addr, mpc);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        minstr = data;
        check1("valid", bus.instr_valid, 1'b1);
        check32("instr", bus.instr, data);
        check32("pc_out", bus.pc_out, mpc);
        check32("pc_plus4", bus.pc_plus4, mpc + 32'd4);
        check1("req_in_valid", bus.imem_req, 1'b0);
    endtask

    // Stall with junk on redirect/ack, then hand over with the given redirect
    task automatic handshake(input int stall, input logic j, input logic b, input logic z,
                             input logic [31:0] off, input logic [25:0] idx);
        logic [31:0] nxt;
        for (int i = 0; i < stall; i++) begin
            bus.instr_ready   = 1'b0;
            bus.jump          = 1'($urandom);
            bus.branch        = 1'($urandom);
            bus.zero          = 1'($urandom);
            bus.branch_offset = $urandom;
            bus.jump_index    = 26'($urandom);
            bus.imem_ack      = 1'($urandom);
            bus.imem_rdata    = $urandom;
            @(negedge clk);
            check1("stall_valid", bus.instr_valid, 1'b1);
            check32("stall_instr", bus.instr, minstr);
            check32("stall_pc", bus.pc_out, mpc);
        end
        bus.imem_ack      = 1'b0;
        bus.instr_ready   = 1'b1;
        bus.jump          = j;
        bus.branch        = b;
        bus.zero          = z;
        bus.branch_offset = off;
        bus.jump_index    = idx;
        nxt = ref_next(mpc, j, b, z, off, idx);
        @(negedge clk);
        bus.instr_ready = 1'b0;
        mpc = nxt;
        check1("hs_req", bus.imem_req, 1'b1);
        check32("hs_addr", bus.imem_addr, mpc);
        check1("hs_valid", bus.instr_valid, 1'b0);
    endtask

    // Move the PC to an aligned target via a taken branch
    task automatic goto_pc(input logic [31:0] target);
        logic [31:0] d;
        fetch_one($urandom, 0);
        d = target - mpc - 32'd4;
        handshake(0, 1'b0, 1'b1, 1'b1, {{2{d[31]}}, d[31:2]}, 26'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"br_taken",     32'h0000_0010, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 26'h0,        32'h0000_000C};
        vecs[1] = '{"br_not_zero",  32'h0000_0010, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0,        32'h0000_0014};
        vecs[2] = '{"jump_prio",    32'h1000_0000, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 26'h40,       32'h1000_0100};
        vecs[3] = '{"pc_wrap",      32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 26'h0,        32'h0000_0000};
        vecs[4] = '{"no_branch",    32'h0000_0020, 1'b0, 1'b0, 1'b1, 32'h0000_0005, 26'h0,        32'h0000_0024};
        vecs[5] = '{"jump_region",  32'h0FFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 26'h3,        32'h1000_000C};
        vecs[6] = '{"off_overflow", 32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h4000_0000, 26'h0,        32'h0000_0104};
        vecs[7] = '{"jump_max",     32'h2000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 26'h3FF_FFFF, 32'h2FFF_FFFC};

        rst_n = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
        bus.jump = 1'b0; bus.branch = 1'b0; bus.zero = 1'b0;
        bus.branch_offset = '0; bus.jump_index = '0;
`ifdef MISALIGN_TRAP_EN
        bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.instr_ready = 1'b0;
        bus2.jump = 1'b0; bus2.branch = 1'b0; bus2.zero = 1'b0;
        bus2.branch_offset = '0; bus2.jump_index = '0;
`endif
        repeat (3) @(negedge clk);

        // Reset state
        check1("rst_req", bus.imem_req, 1'b0);
        check1("rst_valid", bus.instr_valid, 1'b0);
        check32("rst_instr", bus.instr, 32'h0);
        check32("rst_pc", bus.pc_out, 32'h0);

        // Reset release and first fetch
        rst_n = 1'b1;
        mpc = 32'h0;
        @(negedge clk);
        fetch_one(32'h8C01_0004, 0);
        check32("opcode", 32'(bus.instr[31:26]), 32'(OP_LW));

        // Five-cycle decode stall, then sequential advance to 4
        handshake(5, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
        check32("stall_next", bus.imem_addr, 32'h4);

        // Redirect vector table
        for (int v = 0; v < 8; v++) begin
            goto_pc(vecs[v].start_pc);
            fetch_one($urandom, 1);
            handshake(1, vecs[v].j, vecs[v].b, vecs[v].z, vecs[v].off, vecs[v].idx);
            check32(vecs[v].name, bus.imem_addr, vecs[v].exp_addr);
        end

        // Reset during the ack cycle of a fetch
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check1("midfetch_valid", bus.instr_valid, 1'b0);
        check1("midfetch_req", bus.imem_req, 1'b0);
        rst_n = 1'b1;
        mpc = 32'h0;
        @(negedge clk);
        check1("refetch_req", bus.imem_req, 1'b1);
        check32("refetch_addr", bus.imem_addr, 32'h0);
        check1("refetch_valid", bus.instr_valid, 1'b0);
        fetch_one(32'h1234_5678, 0);

        // Reset during a handshake discards the redirect
        bus.instr_ready = 1'b1;
        bus.jump = 1'b1;
        bus.jump_index = 26'h55;
        rst_n = 1'b0;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.jump = 1'b0;
        check1("rst_hs_valid", bus.instr_valid, 1'b0);
        rst_n = 1'b1;
        mpc = 32'h0;
        @(negedge clk);
        check1("rst_hs_req", bus.imem_req, 1'b1);
        check32("rst_hs_addr", bus.imem_addr, 32'h0);

        // Random instruction stream against the PC model
        for (int n = 0; n < 40; n++) begin
            logic        j, b, z;
            logic [31:0] off;
            fetch_one($urandom, int'($urandom_range(0, 3)));
            j   = ($urandom_range(0, 3) == 0);
            b   = 1'($urandom);
            z   = 1'($urandom);
            off = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 64)) - 32);
            handshake(int'($urandom_range(0, 3)), j, b, z, off, 26'($urandom));
        end

`ifdef MISALIGN_TRAP_EN
        // Misaligned RESET_PC forces a misaligned sequential next_pc
        check1("trap_main", trap, 1'b0);
        check1("trap2_idle", trap2, 1'b0);
        check32("trap2_addr", bus2.imem_addr, 32'h2);
        bus2.imem_ack = 1'b1;
        bus2.imem_rdata = 32'hCAFE_0000;
        @(negedge clk);
        bus2.imem_ack = 1'b0;
        check1("trap2_valid", bus2.instr_valid, 1'b1);
        bus2.instr_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus2.imem_ack = 1'b1;
            check1("trap_set", trap2, 1'b1);
            check1("trap_req", bus2.imem_req, 1'b0);
            check1("trap_valid", bus2.instr_valid, 1'b0);
            @(negedge clk);
        end
        bus2.imem_ack = 1'b0;
        bus2.instr_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check1("trap_cleared", trap2, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check1("trap2_refetch", bus2.imem_req, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
